// File: rtl/sha256_core_iter.sv
// sha256_core_iter: iterative SHA-256 compression of one 512-bit block per job.
// RPC rounds are evaluated per clock as a combinational chain. The message
// schedule lives in a 16-word shift window. The chaining value is added back
// in FINAL to form the digest.
module sha256_core_iter #(
   parameter int RPC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         use_iv,
   input  logic [511:0] block_in,
   input  logic [255:0] chain_in,
   output logic         ready,
   output logic         busy,
   output logic         digest_valid,
   output logic [255:0] digest_out
);

   localparam int LAT_R = 64 / RPC;
   // Round counter value seen during the last ROUND cycle.
   localparam logic [5:0] RC_LAST = 6'((LAT_R - 1) * RPC);

   if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
      $error("sha256_core_iter: RPC must be 1, 2, 4 or 8");
   end

   // Index 7 holds a/H0 and index 0 holds h/H7, so the packed vector lines up
   // directly with chain_in and digest_out ([255:224] = H0).
   typedef logic [7:0][31:0]  st_t;
   // Index 15 holds the word used by the current round (W[t]).
   typedef logic [15:0][31:0] win_t;

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

   localparam st_t IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_s0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] big_s1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   function automatic logic [31:0] sm_s0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sm_s1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   // One compression round: s[7..0] = a..h.
   function automatic st_t round_f(input st_t s, input logic [31:0] k, input logic [31:0] w);
      logic [31:0] t1, t2;
      st_t r;
      t1 = s[0] + big_s1(s[3]) + ((s[3] & s[2]) ^ (~s[3] & s[1])) + k + w;
      t2 = big_s0(s[7]) + ((s[7] & s[6]) ^ (s[7] & s[5]) ^ (s[6] & s[5]));
      r[0] = s[1];
      r[1] = s[2];
      r[2] = s[3];
      r[3] = s[4] + t1;
      r[4] = s[5];
      r[5] = s[6];
      r[6] = s[7];
      r[7] = t1 + t2;
      return r;
   endfunction

   // Advance the window by one word. W[t+j] sits at index 15-j. The word
   // shifted in is W[t+16]; it is also produced during rounds 0-15, where the
   // window still holds latched words, and it is first consumed at round 16.
   function automatic win_t sched_f(input win_t w);
      win_t r;
      r[15:1] = w[14:0];
      r[0]    = sm_s1(w[1]) + w[6] + sm_s0(w[14]) + w[15];
      return r;
   endfunction

   state_t       state_q, state_d;
   logic [5:0]   rc_q, rc_d;
   win_t         w_q, w_d, w_nx;
   st_t          st_q, st_d, st_nx;
   st_t          hv_q, hv_d;
   logic [255:0] digest_q, digest_d;
   logic         dv_q, dv_d;

   // RPC chained rounds and schedule steps evaluated from the current registers.
   always_comb begin
      st_t  s;
      win_t w;
      s = st_q;
      w = w_q;
      for (int i = 0; i < RPC; i++) begin
         s = round_f(s, K[rc_q + 6'(i)], w[15]);
         w = sched_f(w);
      end
      st_nx = s;
      w_nx  = w;
   end

   // Next-state logic and datapath register updates.
   always_comb begin
      state_d  = state_q;
      rc_d     = rc_q;
      w_d      = w_q;
      st_d     = st_q;
      hv_d     = hv_q;
      digest_d = digest_q;
      dv_d     = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_ROUND;
               rc_d    = '0;
               w_d     = block_in;
               hv_d    = use_iv ? IV : chain_in;
               st_d    = use_iv ? IV : chain_in;
            end
         end
         S_ROUND: begin
            st_d = st_nx;
            w_d  = w_nx;
            rc_d = rc_q + 6'(RPC);
            if (rc_q == RC_LAST) state_d = S_FINAL;
         end
         S_FINAL: begin
            for (int j = 0; j < 8; j++) digest_d[32*j +: 32] = hv_q[j] + st_q[j];
            dv_d    = 1'b1;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rc_q     <= '0;
         w_q      <= '0;
         st_q     <= '0;
         hv_q     <= '0;
         digest_q <= '0;
         dv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         rc_q     <= rc_d;
         w_q      <= w_d;
         st_q     <= st_d;
         hv_q     <= hv_d;
         digest_q <= digest_d;
         dv_q     <= dv_d;
      end
   end

   assign ready        = (state_q == S_IDLE) || (state_q == S_DONE);
   assign busy         = (state_q == S_ROUND) || (state_q == S_FINAL);
   assign digest_valid = dv_q;
   assign digest_out   = digest_q;

endmodule

// File: tb/tb_sha256_core_iter.sv
// Bench for sha256_core_iter: known-answer vectors, chaining, latency for every
// RPC, back-to-back jobs, ignored start and mid-job reset.
module tb_sha256_core_iter;

   localparam logic [511:0] T1_BLK = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] T2_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] T3_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] T3_B2  = {480'h0, 32'h000001c0};
   localparam logic [255:0] T1_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] T2_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] T3_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   localparam logic [255:0] IV     = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start, use_iv;
   logic [511:0] block_in;
   logic [255:0] chain_in;
   logic         rdy [4];
   logic         bsy [4];
   logic         dv  [4];
   logic [255:0] dig [4];

   // Instance g runs with RPC = 2**g; all share the same stimulus.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      sha256_core_iter #(.RPC(1 << g)) u_dut (
         .clk(clk), .rst(rst), .start(start), .use_iv(use_iv),
         .block_in(block_in), .chain_in(chain_in),
         .ready(rdy[g]), .busy(bsy[g]), .digest_valid(dv[g]), .digest_out(dig[g])
      );
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Accept one job on instance 0 and wait (bounded) for its digest pulse.
   task automatic run_job(input logic iv, input logic [511:0] blk, input logic [255:0] ch,
                          output logic [255:0] d, output int lat);
      start = 1'b1; use_iv = iv; block_in = blk; chain_in = ch;
      tick();
      start = 1'b0;
      lat = 0;
      while (!dv[0] && lat < 200) begin
         tick();
         lat++;
      end
      d = dig[0];
   endtask

   typedef struct {
      logic         iv;
      logic [511:0] blk;
      logic [255:0] ch;
      logic [255:0] exp;
   } vec_t;

   initial begin
      vec_t         vt [4];
      logic [255:0] d;
      int           lat, k;

      vt[0] = '{1'b1, T1_BLK, 256'h0, T1_DIG};
      vt[1] = '{1'b1, T2_BLK, {8{32'hdeadbeef}}, T2_DIG};
      vt[2] = '{1'b0, T1_BLK, IV, T1_DIG};
      vt[3] = '{1'b0, T2_BLK, IV, T2_DIG};

      rst = 1'b1; start = 1'b0; use_iv = 1'b0; block_in = '0; chain_in = '0;
      tick(); tick();
      rst = 1'b0;
      chk("reset_ready", 256'(rdy[0]), 256'd1);
      chk("reset_busy", 256'(bsy[0]), 256'd0);
      chk("reset_valid", 256'(dv[0]), 256'd0);
      chk("reset_digest", dig[0], 256'h0);

      // Known-answer table, including chaining from an explicit IV on chain_in.
      for (int i = 0; i < 4; i++) begin
         run_job(vt[i].iv, vt[i].blk, vt[i].ch, d, lat);
         chk($sformatf("vec%0d_digest", i), d, vt[i].exp);
         chk($sformatf("vec%0d_latency", i), 256'(lat), 256'd65);
      end

      // Two-block message, second block chained from the first digest.
      run_job(1'b1, T3_B1, 256'h0, d, lat);
      run_job(1'b0, T3_B2, d, d, lat);
      chk("two_block_digest", d, T3_DIG);

      // Back-to-back: start held high, second accept lands in DONE.
      start = 1'b1; use_iv = 1'b1; block_in = T1_BLK; chain_in = '0;
      tick();
      block_in = T2_BLK;
      k = 0;
      while (!dv[0] && k < 200) begin tick(); k++; end
      chk("b2b_first_latency", 256'(k), 256'd65);
      chk("b2b_first_digest", dig[0], T1_DIG);
      chk("b2b_ready_in_done", 256'(rdy[0]), 256'd1);
      tick();
      chk("b2b_second_accept_busy", 256'(bsy[0]), 256'd1);
      chk("b2b_valid_dropped", 256'(dv[0]), 256'd0);
      chk("b2b_digest_held", dig[0], T1_DIG);
      start = 1'b0;
      k = 1;
      while (!dv[0] && k < 200) begin tick(); k++; end
      chk("b2b_pulse_spacing", 256'(k), 256'd66);
      chk("b2b_second_digest", dig[0], T2_DIG);

      // start pulsed during ROUND is ignored; inputs change mid-job too.
      start = 1'b1; use_iv = 1'b1; block_in = T1_BLK; chain_in = '0;
      tick();
      k = 0;
      while (!dv[0] && k < 200) begin
         if (k == 10) begin
            start = 1'b1; block_in = T2_BLK; use_iv = 1'b0;
         end else begin
            start = 1'b0;
         end
         tick();
         k++;
      end
      start = 1'b0;
      chk("ignored_start_latency", 256'(k), 256'd65);
      chk("ignored_start_digest", dig[0], T1_DIG);
      tick(); tick();
      chk("ignored_start_idle", 256'(bsy[0]), 256'd0);

      // Reset at rc=20 discards the job.
      run_job(1'b1, T1_BLK, 256'h0, d, lat);
      start = 1'b1; use_iv = 1'b1; block_in = T2_BLK;
      tick();
      start = 1'b0;
      repeat (20) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_ready", 256'(rdy[0]), 256'd1);
      chk("midrst_busy", 256'(bsy[0]), 256'd0);
      chk("midrst_valid", 256'(dv[0]), 256'd0);
      chk("midrst_digest", dig[0], 256'h0);
      k = 0;
      repeat (80) begin
         if (dv[0]) k++;
         tick();
      end
      chk("midrst_no_pulse", 256'(k), 256'd0);
      run_job(1'b1, T1_BLK, 256'h0, d, lat);
      chk("midrst_after_digest", d, T1_DIG);
      chk("midrst_after_latency", 256'(lat), 256'd65);

      // Latency and ready window for every RPC, all instances in parallel.
      begin
         int first [4];
         int low   [4];
         int np    [4];
         rst = 1'b1;
         tick();
         rst = 1'b0;
         for (int g = 0; g < 4; g++) begin first[g] = -1; low[g] = 0; np[g] = 0; end
         start = 1'b1; use_iv = 1'b1; block_in = T1_BLK; chain_in = '0;
         tick();
         start = 1'b0;
         for (int c = 0; c < 90; c++) begin
            for (int g = 0; g < 4; g++) begin
               if (!rdy[g]) low[g]++;
               if (dv[g]) begin
                  np[g]++;
                  if (first[g] < 0) first[g] = c;
               end
            end
            tick();
         end
         for (int g = 0; g < 4; g++) begin
            chk($sformatf("rpc%0d_latency", 1 << g), 256'(first[g]), 256'(64 / (1 << g) + 1));
            chk($sformatf("rpc%0d_ready_low", 1 << g), 256'(low[g]), 256'(64 / (1 << g) + 1));
            chk($sformatf("rpc%0d_pulses", 1 << g), 256'(np[g]), 256'd1);
            chk($sformatf("rpc%0d_digest", 1 << g), dig[g], T1_DIG);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
